// File: rtl/microcode_seq.sv
// Microcode sequencer: fetches from a synchronous ROM, decodes and executes LED/WAIT/JMP/LOOP/SETCNT/HALT.
// Each instruction takes a fetch cycle and a decode cycle; WAIT adds dly24 cycles. rom_en is asserted only while fetching.
module microcode_seq #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 9,
    parameter int LEDS  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    output logic             rom_en,
    output logic [DEPTH-1:0] rom_addr,
    input  logic [DEPTH-1:0] rom_daddr,
    input  logic [WIDTH-1:0] rom_dout,
    output logic [LEDS-1:0]  leds,
    output logic             busy,
    output logic             halted,
    output logic             error
);
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_WAIT, S_HALT} state_t;

    localparam logic [3:0] OP_LED    = 4'd1;
    localparam logic [3:0] OP_WAIT   = 4'd2;
    localparam logic [3:0] OP_JMP    = 4'd3;
    localparam logic [3:0] OP_LOOP   = 4'd4;
    localparam logic [3:0] OP_SETCNT = 4'd5;
    localparam logic [3:0] OP_HALT   = 4'd6;

    state_t            state, state_nxt;
    logic [DEPTH-1:0]  pc, pc_nxt;
    logic [15:0]       loop_cnt, loop_nxt;
    logic [23:0]       dly, dly_nxt;
    logic [LEDS-1:0]   leds_nxt;
    logic              error_nxt;
    logic              rom_en_nxt;
    logic [DEPTH-1:0]  rom_addr_nxt;

    logic [3:0]        opcode;
    logic [DEPTH-1:0]  tgt;
    logic [15:0]       cnt16;
    logic [23:0]       dly24;
    logic              addr_ok;
    logic              start;
    logic              dout_unused;

    assign opcode      = rom_dout[WIDTH-1 -: 4];
    assign tgt         = rom_dout[DEPTH-1:0];
    assign cnt16       = rom_dout[15:0];
    assign dly24       = rom_dout[23:0];
    assign addr_ok     = (rom_daddr == pc);
    assign start       = ((state == S_IDLE) || (state == S_HALT)) && run;
    assign dout_unused = ^rom_dout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            pc       <= '0;
            loop_cnt <= '0;
            dly      <= '0;
            rom_en   <= 1'b0;
            rom_addr <= '0;
            leds     <= '0;
            error    <= 1'b0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            loop_cnt <= loop_nxt;
            dly      <= dly_nxt;
            rom_en   <= rom_en_nxt;
            rom_addr <= rom_addr_nxt;
            leds     <= leds_nxt;
            error    <= error_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_HALT: if (run) state_nxt = S_FETCH;
            S_FETCH:        state_nxt = S_DECODE;
            S_DECODE: begin
                if (!addr_ok)                             state_nxt = S_HALT;
                else if (opcode == OP_HALT)               state_nxt = S_HALT;
                else if (opcode == OP_WAIT && dly24 != 0) state_nxt = S_WAIT;
                else                                      state_nxt = S_FETCH;
            end
            S_WAIT:         if (dly <= 24'd1) state_nxt = S_FETCH;
            default:        state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        pc_nxt    = pc;
        loop_nxt  = loop_cnt;
        dly_nxt   = dly;
        leds_nxt  = leds;
        error_nxt = error;
        if (start) begin
            pc_nxt    = '0;
            error_nxt = 1'b0;
        end
        if (state == S_DECODE) begin
            if (!addr_ok) begin
                error_nxt = 1'b1;
            end else begin
                pc_nxt = pc + 1'b1;
                case (opcode)
                    OP_LED:    leds_nxt = rom_dout[LEDS-1:0];
                    OP_WAIT:   dly_nxt  = dly24;
                    OP_JMP:    pc_nxt   = tgt;
                    OP_LOOP: begin
                        if (loop_cnt != 16'd0) begin
                            loop_nxt = loop_cnt - 16'd1;
                            pc_nxt   = tgt;
                        end
                    end
                    OP_SETCNT: loop_nxt = cnt16;
                    OP_HALT:   pc_nxt   = pc;
                    default:   ;
                endcase
            end
        end
        if (state == S_WAIT) dly_nxt = dly - 24'd1;
        // rom_en/rom_addr are registered, so they are set up on the edge that enters FETCH.
        rom_en_nxt   = (state_nxt == S_FETCH);
        rom_addr_nxt = (state_nxt == S_FETCH) ? pc_nxt : rom_addr;
        busy         = (state == S_FETCH) || (state == S_DECODE) || (state == S_WAIT);
        halted       = (state == S_HALT);
    end
endmodule

// File: tb/tb_microcode_seq.sv
// Directed bench for microcode_seq with a behavioural synchronous ROM.
module tb_microcode_seq;
    localparam int WIDTH = 32;
    localparam int DEPTH = 9;
    localparam int LEDS  = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             run = 1'b0;
    logic             rom_en;
    logic [DEPTH-1:0] rom_addr;
    logic [DEPTH-1:0] rom_daddr = '0;
    logic [WIDTH-1:0] rom_dout = '0;
    logic [LEDS-1:0]  leds;
    logic             busy;
    logic             halted;
    logic             error;

    int checks = 0;
    int errors = 0;
    int daddr_off = 0;
    logic [WIDTH-1:0] mem [0:511];

    microcode_seq #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LEDS(LEDS)) dut (
        .clk(clk), .rst_n(rst_n), .run(run),
        .rom_en(rom_en), .rom_addr(rom_addr),
        .rom_daddr(rom_daddr), .rom_dout(rom_dout),
        .leds(leds), .busy(busy), .halted(halted), .error(error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rom_en) begin
            rom_dout  <= mem[rom_addr];
            rom_daddr <= rom_addr + DEPTH'(daddr_off);
        end
    end

    function automatic logic [31:0] ins(input logic [3:0] op, input logic [27:0] arg);
        return {op, arg};
    endfunction

    task automatic clear_mem;
        for (int i = 0; i < 512; i++) mem[i] = 32'h0;
    endtask

    task automatic do_reset;
        @(negedge clk) rst_n = 1'b0; run = 1'b0;
        @(negedge clk) rst_n = 1'b1;
    endtask

    // Leaves the bench at the falling edge just after the edge that sampled run.
    task automatic pulse_run;
        @(negedge clk) run = 1'b1;
        @(negedge clk) run = 1'b0;
    endtask

    task automatic test_reset;
        int seen;
        rst_n = 1'b0; run = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({rom_en, rom_addr, leds, busy, halted, error} !== '0) begin
                errors++;
                $display("FAIL reset_outputs got en=%b addr=%0d leds=%h busy=%b halted=%b err=%b want all 0",
                         rom_en, rom_addr, leds, busy, halted, error);
            end
        end
        rst_n = 1'b1; run = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rom_en !== 1'b0 || busy !== 1'b0 || leds !== '0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL idle_quiet got %0d active cycles want 0", seen);
        end
        pulse_run;
        checks++;
        if (rom_en !== 1'b1 || rom_addr !== 9'd0) begin
            errors++;
            $display("FAIL first_fetch got en=%b addr=%0d want en=1 addr=0", rom_en, rom_addr);
        end
        do_reset;
    endtask

    task automatic test_led_halt;
        clear_mem;
        mem[0] = ins(4'd1, 28'hA5);
        mem[1] = ins(4'd6, 28'h0);
        do_reset;
        pulse_run;
        @(negedge clk);
        checks++;
        if (leds !== 8'h00) begin
            errors++;
            $display("FAIL led_early got %h want 00", leds);
        end
        @(negedge clk);
        checks++;
        if (leds !== 8'hA5) begin
            errors++;
            $display("FAIL led_value got %h want a5", leds);
        end
        checks++;
        if (rom_en !== 1'b1 || rom_addr !== 9'd1) begin
            errors++;
            $display("FAIL second_fetch got en=%b addr=%0d want en=1 addr=1", rom_en, rom_addr);
        end
        @(negedge clk);
        checks++;
        if (halted !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL halt_early got halted=%b busy=%b want 0 1", halted, busy);
        end
        @(negedge clk);
        checks++;
        if (halted !== 1'b1 || busy !== 1'b0 || rom_en !== 1'b0) begin
            errors++;
            $display("FAIL halt_state got halted=%b busy=%b en=%b want 1 0 0", halted, busy, rom_en);
        end
    endtask

    task automatic test_wait(input int n, input int gap);
        int c, t1, t2;
        clear_mem;
        mem[0] = ins(4'd1, 28'h01);
        mem[1] = ins(4'd2, 28'(n));
        mem[2] = ins(4'd1, 28'h02);
        mem[3] = ins(4'd6, 28'h0);
        do_reset;
        pulse_run;
        c = 0; t1 = -1; t2 = -1;
        while (halted !== 1'b1 && c < 200) begin
            if (leds === 8'h01 && t1 < 0) t1 = c;
            if (leds === 8'h02 && t2 < 0) t2 = c;
            @(negedge clk);
            c++;
        end
        checks++;
        if (halted !== 1'b1) begin
            errors++;
            $display("FAIL wait_timeout dly=%0d halted=%b want 1", n, halted);
        end
        checks++;
        if (t2 - t1 != gap || t1 < 0) begin
            errors++;
            $display("FAIL wait_gap dly=%0d got %0d want %0d", n, t2 - t1, gap);
        end
    endtask

    task automatic test_loop;
        int c, n1, n2;
        logic [LEDS-1:0] prev;
        clear_mem;
        mem[0] = ins(4'd5, 28'd3);
        mem[1] = ins(4'd1, 28'h01);
        mem[2] = ins(4'd1, 28'h02);
        mem[3] = ins(4'd4, 28'd1);
        mem[4] = ins(4'd6, 28'h0);
        do_reset;
        pulse_run;
        c = 0; n1 = 0; n2 = 0; prev = leds;
        while (halted !== 1'b1 && c < 400) begin
            @(negedge clk);
            c++;
            if (leds !== prev) begin
                if (leds === 8'h01) n1++;
                else if (leds === 8'h02) n2++;
                prev = leds;
            end
        end
        checks++;
        if (n1 != 4 || n2 != 4) begin
            errors++;
            $display("FAIL loop_writes got led1=%0d led2=%0d want 4 4", n1, n2);
        end
        checks++;
        if (halted !== 1'b1 || dut.loop_cnt !== 16'd0) begin
            errors++;
            $display("FAIL loop_end got halted=%b loop_cnt=%0d want 1 0", halted, dut.loop_cnt);
        end
    endtask

    task automatic test_jmp_wrap;
        logic [DEPTH-1:0] fa [$];
        int c;
        clear_mem;
        mem[0]   = ins(4'd3, 28'd511);
        mem[511] = ins(4'd0, 28'h0);
        do_reset;
        pulse_run;
        c = 0;
        while (fa.size() < 3 && c < 20) begin
            if (rom_en === 1'b1) fa.push_back(rom_addr);
            @(negedge clk);
            c++;
        end
        checks++;
        if (fa.size() != 3) begin
            errors++;
            $display("FAIL wrap_fetches got %0d fetches want 3", fa.size());
        end else begin
            checks++;
            if (fa[0] !== 9'd0 || fa[1] !== 9'd511 || fa[2] !== 9'd0) begin
                errors++;
                $display("FAIL wrap_addrs got %0d,%0d,%0d want 0,511,0", fa[0], fa[1], fa[2]);
            end
        end
        do_reset;
    endtask

    task automatic test_addr_mismatch;
        clear_mem;
        mem[0] = ins(4'd1, 28'h55);
        daddr_off = 1;
        do_reset;
        pulse_run;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (error !== 1'b1 || halted !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mismatch_flags got err=%b halted=%b busy=%b want 1 1 0", error, halted, busy);
        end
        checks++;
        if (leds !== 8'h00) begin
            errors++;
            $display("FAIL mismatch_leds got %h want 00", leds);
        end
        daddr_off = 0;
        mem[0] = ins(4'd6, 28'h0);
        pulse_run;
        checks++;
        if (error !== 1'b0 || halted !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rerun_clear got err=%b halted=%b busy=%b want 0 0 1", error, halted, busy);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (halted !== 1'b1 || error !== 1'b0) begin
            errors++;
            $display("FAIL rerun_halt got halted=%b err=%b want 1 0", halted, error);
        end
    endtask

    task automatic test_reset_mid_wait;
        int seen;
        clear_mem;
        mem[0] = ins(4'd2, 28'd100);
        do_reset;
        pulse_run;
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL midwait_busy got %b want 1", busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || rom_en !== 1'b0 || rom_addr !== 9'd0) begin
            errors++;
            $display("FAIL async_reset got busy=%b en=%b addr=%0d want 0 0 0", busy, rom_en, rom_addr);
        end
        @(negedge clk) rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rom_en !== 1'b0 || busy !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL post_reset_idle got %0d active cycles want 0", seen);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        clear_mem;
        test_reset;
        test_led_halt;
        test_wait(5, 9);
        test_wait(0, 4);
        test_loop;
        test_jmp_wrap;
        test_addr_mismatch;
        test_reset_mid_wait;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
